// File: rtl/mem_access_pkg.sv
// Shared constants, state encoding and size decode for the MEM stage.
// Imported by the bus interface, the load extender and the stage top.
package mem_access_pkg;

   localparam int XLEN   = 32;
   localparam int BYTE_W = 8;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;

   localparam logic [XLEN-1:0] ZERO_WORD    = '0;
   localparam logic            RST_ENABLE_N = 1'b0;

   typedef enum logic [1:0] {
      MEM_IDLE   = 2'd0,
      MEM_ACCESS = 2'd1,
      MEM_DONE   = 2'd2
   } mem_state_e;

   // Index of the final beat; the reserved size code 11 behaves as a word.
   function automatic logic [1:0] last_beat(input logic [2:0] func3);
      logic [1:0] idx;
      case (func3[1:0])
         SIZE_B:  idx = 2'd0;
         SIZE_H:  idx = 2'd1;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide request/acknowledge port between the MEM stage and the RAM controller.
// Handshake: req/we/addr/wdata are held stable until ack is sampled high at a rising edge;
// on a read beat rdata is valid in the same cycle as ack.
interface mem_access_if;
   import mem_access_pkg::*;

   logic              req;
   logic              we;
   logic [XLEN-1:0]   addr;
   logic [BYTE_W-1:0] wdata;
   logic              ack;
   logic [BYTE_W-1:0] rdata;

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output ack,
      output rdata
   );

endinterface

// File: rtl/mem_access_load_extend.sv
// Sign/zero extension of the assembled load word according to the access size.
module mem_access_load_extend
   import mem_access_pkg::*;
(
   input  logic [XLEN-1:0] raw,
   input  logic [2:0]      func3,
   output logic [XLEN-1:0] result
);

   always_comb begin
      result = raw;
      case (func3[1:0])
         SIZE_B: result = func3[2] ? {{(XLEN-8){1'b0}}, raw[7:0]}
                                   : {{(XLEN-8){raw[7]}}, raw[7:0]};
         SIZE_H: result = func3[2] ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                   : {{(XLEN-16){raw[15]}}, raw[15:0]};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM stage: forwards ALU/link results to WB and runs loads/stores byte-serially over
// the 8-bit RAM port, holding upstream stages until the access has finished.
module mem_access
   import mem_access_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              ifload_i,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        func3_i,
   input  logic [XLEN-1:0]   mem_addr_i,
   input  logic [XLEN-1:0]   store_data_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic              stall_req_o,
   mem_access_if.master      bus,
   output logic              valid_o,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [XLEN-1:0]   wdata_o,
   output mem_state_e        dbg_state
);

   mem_state_e      state_q;
   logic [1:0]      cnt_q;
   logic [1:0]      last_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] data_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] rbuf_q;
   logic [2:0]      func3_q;
   logic            load_q;
   logic            store_q;
   logic [4:0]      wd_q;
   logic            wreg_q;

   logic            rst_off;
   logic            is_mem;
   logic            start;
   logic            in_access;
   logic [XLEN-1:0] ext_data;

   assign rst_off   = (rst != RST_ENABLE_N);
   assign is_mem    = ifload_i | (opcode_i == OP_STORE);
   assign start     = rst_off & (state_q == MEM_IDLE) & valid_i & is_mem;
   assign in_access = (state_q == MEM_ACCESS);

   // Stall is raised in the same cycle a memory op is offered so EX holds its bundle.
   assign stall_req_o = rst_off & (start | in_access);

   assign bus.req   = in_access;
   assign bus.we    = in_access & store_q;
   assign bus.addr  = in_access ? (addr_q + {{(XLEN-2){1'b0}}, cnt_q}) : ZERO_WORD;
   assign bus.wdata = in_access ? data_q[{cnt_q, 3'b000} +: BYTE_W] : '0;

   assign dbg_state = state_q;

   mem_access_load_extend u_load_extend (
      .raw    (rbuf_q),
      .func3  (func3_q),
      .result (ext_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE_N) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
         last_q  <= '0;
         addr_q  <= ZERO_WORD;
         data_q  <= ZERO_WORD;
         wdata_q <= ZERO_WORD;
         rbuf_q  <= ZERO_WORD;
         func3_q <= '0;
         load_q  <= 1'b0;
         store_q <= 1'b0;
         wd_q    <= '0;
         wreg_q  <= 1'b0;
         valid_o <= 1'b0;
         wd_o    <= '0;
         wreg_o  <= 1'b0;
         wdata_o <= ZERO_WORD;
      end else begin
         case (state_q)
            MEM_IDLE: begin
               valid_o <= 1'b0;
               wreg_o  <= 1'b0;
               if (start) begin
                  addr_q  <= mem_addr_i;
                  data_q  <= store_data_i;
                  wdata_q <= wdata_i;
                  func3_q <= func3_i;
                  last_q  <= last_beat(func3_i);
                  load_q  <= ifload_i;
                  store_q <= ~ifload_i;
                  wd_q    <= wd_i;
                  wreg_q  <= wreg_i;
                  rbuf_q  <= ZERO_WORD;
                  cnt_q   <= '0;
                  state_q <= MEM_ACCESS;
               end else if (valid_i) begin
                  valid_o <= 1'b1;
                  wd_o    <= wd_i;
                  wreg_o  <= wreg_i;
                  wdata_o <= wdata_i;
               end
            end

            // Without ack every request output stays frozen; there is no timeout.
            MEM_ACCESS: begin
               if (bus.ack) begin
                  if (load_q) begin
                     rbuf_q[{cnt_q, 3'b000} +: BYTE_W] <= bus.rdata;
                  end
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == last_q) begin
                     state_q <= MEM_DONE;
                  end
               end
            end

            MEM_DONE: begin
               valid_o <= 1'b1;
               wd_o    <= wd_q;
               wreg_o  <= wreg_q;
               wdata_o <= load_q ? ext_data : wdata_q;
               state_q <= MEM_IDLE;
            end

            default: state_q <= MEM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Bench for the MEM stage: a RAM-port responder checks every beat against an expected
// address/byte queue and a WB scoreboard pops expected bundles whenever valid_o is high.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        ifload_i = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  func3_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        stall_req_o;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  mem_state_e  dbg_state;

  mem_access_if bus_if();

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ifload_i     (ifload_i),
    .opcode_i     (opcode_i),
    .func3_i      (func3_i),
    .mem_addr_i   (mem_addr_i),
    .store_data_i (store_data_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .stall_req_o  (stall_req_o),
    .bus          (bus_if.master),
    .valid_o      (valid_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [37:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [7:0]  byte_q[$];
  logic [37:0] wb_exp;

  int   hold_cnt = 0;
  int   max_hold = 0;
  int   hold_total = 0;
  logic we_exp = 1'b0;
  logic spurious = 1'b0;

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] raw);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'b01:   r = f3[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // RAM responder and WB scoreboard, sampling just after the falling edge
  initial begin
    bus_if.ack = 1'b0;
    bus_if.rdata = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (valid_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected got %h", {wd_o, wreg_o, wdata_o});
        end else begin
          wb_exp = exp_q.pop_front();
          if ({wd_o, wreg_o, wdata_o} !== wb_exp) begin
            errors++;
            $display("FAIL wb_bundle got wd %0d wreg %b wdata %h exp wd %0d wreg %b wdata %h",
                     wd_o, wreg_o, wdata_o, wb_exp[37:33], wb_exp[32], wb_exp[31:0]);
          end
        end
      end
      bus_if.ack = 1'b0;
      bus_if.rdata = 8'h00;
      if (bus_if.req === 1'b1) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got addr %h", bus_if.addr);
        end else begin
          if (bus_if.addr !== addr_q[0] || bus_if.we !== we_exp ||
              (we_exp && bus_if.wdata !== byte_q[0])) begin
            errors++;
            $display("FAIL beat got addr %h we %b wdata %h exp addr %h we %b byte %h",
                     bus_if.addr, bus_if.we, bus_if.wdata, addr_q[0], we_exp, byte_q[0]);
          end
          if (hold_cnt > 0) begin
            hold_cnt--;
            hold_total++;
          end else begin
            bus_if.ack = 1'b1;
            if (!we_exp) bus_if.rdata = byte_q[0];
            void'(addr_q.pop_front());
            void'(byte_q.pop_front());
            hold_cnt = (max_hold > 0) ? int'($urandom_range(max_hold, 0)) : 0;
          end
        end
      end else if (spurious) begin
        bus_if.ack = 1'b1;
        bus_if.rdata = 8'hFF;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    valid_i = 1'b1;
    ifload_i = 1'b1;
    opcode_i = OP_LOAD;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if ({stall_req_o, bus_if.req, bus_if.we, valid_o, wreg_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {stall_req_o, bus_if.req, bus_if.we, valid_o, wreg_o});
    end
    checks++;
    if (bus_if.addr !== 32'h0 || bus_if.wdata !== 8'h0 || wd_o !== 5'h0 || wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got addr %h wdata %h wd %0d wdata_o %h exp zeros",
               bus_if.addr, bus_if.wdata, wd_o, wdata_o);
    end
    checks++;
    if (dbg_state !== MEM_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state, MEM_IDLE);
    end
    valid_i = 1'b0;
    ifload_i = 1'b0;
    opcode_i = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alu(input logic [4:0] wd, input logic wr, input logic [31:0] data,
                          input logic wait_result);
    @(negedge clk);
    valid_i = 1'b1;
    ifload_i = 1'b0;
    opcode_i = OP_ALU;
    func3_i = 3'b000;
    wd_i = wd;
    wreg_i = wr;
    wdata_i = data;
    exp_q.push_back({wd, wr, data});
    #2;
    checks++;
    if (stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall got %b exp 0", stall_req_o);
    end
    if (wait_result) begin
      @(negedge clk);
      valid_i = 1'b0;
      #2;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL alu_latency got pending %0d exp 0", exp_q.size());
      end
    end
  endtask

  task automatic run_mem(input string name, input logic is_load, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rbytes, input logic [31:0] exp_load,
                         input logic [4:0] wd, input logic wr, input logic [31:0] alu,
                         input int h0, input int hmax, input logic scramble);
    int n;
    int stalls;
    int lat;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    we_exp = !is_load;
    hold_cnt = h0;
    max_hold = hmax;
    hold_total = 0;
    for (int k = 0; k < n; k++) begin
      addr_q.push_back(addr + 32'(k));
      byte_q.push_back(is_load ? rbytes[8*k +: 8] : sdata[8*k +: 8]);
    end
    exp_q.push_back({wd, wr, is_load ? exp_load : alu});
    @(negedge clk);
    valid_i = 1'b1;
    ifload_i = is_load;
    opcode_i = is_load ? OP_LOAD : OP_STORE;
    func3_i = f3;
    mem_addr_i = addr;
    store_data_i = sdata;
    wd_i = wd;
    wreg_i = wr;
    wdata_i = alu;
    stalls = 0;
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      #2;
      if (c == 0) begin
        checks++;
        if (stall_req_o !== 1'b1) begin
          errors++;
          $display("FAIL %s_stall_first got %b exp 1", name, stall_req_o);
        end
      end
      if (stall_req_o === 1'b1) stalls++;
      else if (c > 0) valid_i = 1'b0;
      if (exp_q.size() == 0) begin
        lat = c;
        break;
      end
      if (scramble && stall_req_o && c > 0) begin
        mem_addr_i = $urandom;
        store_data_i = $urandom;
        wdata_i = $urandom;
        wd_i = 5'($urandom);
        func3_i = 3'($urandom);
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    checks++;
    if (lat != n + 2 + hold_total) begin
      errors++;
      $display("FAIL %s_latency got %0d exp %0d", name, lat, n + 2 + hold_total);
    end
    checks++;
    if (stalls != n + 1 + hold_total) begin
      errors++;
      $display("FAIL %s_stall_cycles got %0d exp %0d", name, stalls, n + 1 + hold_total);
    end
    checks++;
    if (addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_beats_left got %0d exp 0", name, addr_q.size());
      addr_q.delete();
      byte_q.delete();
    end
  endtask

  task automatic test_loads();
    run_mem("lw", 1'b1, LW, 32'h100, 32'h0, 32'h12345678, 32'h12345678, 5'd7, 1'b1, 32'h0, 0, 0, 1'b0);
    run_mem("lb", 1'b1, LB, 32'h7, 32'h0, 32'h00000080, 32'hFFFFFF80, 5'd3, 1'b1, 32'h0, 0, 0, 1'b0);
    run_mem("lbu", 1'b1, LBU, 32'h7, 32'h0, 32'h00000080, 32'h00000080, 5'd4, 1'b1, 32'h0, 0, 0, 1'b0);
    run_mem("lh", 1'b1, LH, 32'h13, 32'h0, 32'h00008000, 32'hFFFF8000, 5'd8, 1'b1, 32'h0, 0, 0, 1'b0);
    run_mem("lhu", 1'b1, LHU, 32'h13, 32'h0, 32'h00008000, 32'h00008000, 5'd9, 1'b1, 32'h0, 0, 0, 1'b0);
    run_mem("lw_rsv", 1'b1, 3'b011, 32'h200, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 5'd0, 1'b1, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_store_hold();
    run_mem("sh", 1'b0, SH, 32'h20, 32'hAABBCCDD, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0BADF00D, 3, 0, 1'b0);
    run_mem("sw", 1'b0, SW, 32'h31, 32'h11223344, 32'h0, 32'h0, 5'd2, 1'b0, 32'h00000035, 1, 1, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    we_exp = 1'b0;
    hold_cnt = 0;
    max_hold = 0;
    for (int k = 0; k < 4; k++) begin
      addr_q.push_back(32'h40 + 32'(k));
      byte_q.push_back(8'(8'h11 * (k + 1)));
    end
    @(negedge clk);
    valid_i = 1'b1;
    ifload_i = 1'b1;
    opcode_i = OP_LOAD;
    func3_i = LW;
    mem_addr_i = 32'h40;
    wd_i = 5'd6;
    wreg_i = 1'b1;
    for (int c = 0; c < 20 && addr_q.size() > 2; c++) begin
      @(negedge clk);
      #2;
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.req !== 1'b1 || bus_if.addr !== 32'h42) begin
      errors++;
      $display("FAIL rst_mid_beat2 got req %b addr %h exp req 1 addr 00000042", bus_if.req, bus_if.addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_if.req !== 1'b0 || stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop got req %b stall %b exp 0 0", bus_if.req, stall_req_o);
    end
    checks++;
    if (dbg_state !== MEM_IDLE) begin
      errors++;
      $display("FAIL rst_mid_state got %0d exp %0d", dbg_state, MEM_IDLE);
    end
    addr_q.delete();
    byte_q.delete();
    valid_i = 1'b0;
    ifload_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    checks++;
    if (valid_o !== 1'b0 || dbg_state !== MEM_IDLE) begin
      errors++;
      $display("FAIL rst_mid_after got valid %b state %0d exp 0 %0d", valid_o, dbg_state, MEM_IDLE);
    end
    test_alu(5'd10, 1'b1, 32'hCAFE0001, 1'b1);
  endtask

  task automatic test_wrap_and_spurious();
    run_mem("lw_wrap", 1'b1, LW, 32'hFFFFFFFE, 32'h0, 32'hA1B2C3D4, 32'hA1B2C3D4, 5'd11, 1'b1, 32'h0, 0, 0, 1'b0);
    spurious = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      checks++;
      if (bus_if.req !== 1'b0 || valid_o !== 1'b0 || dbg_state !== MEM_IDLE) begin
        errors++;
        $display("FAIL spurious_ack got req %b valid %b state %0d exp 0 0 %0d",
                 bus_if.req, valid_o, dbg_state, MEM_IDLE);
      end
    end
    spurious = 1'b0;
    run_mem("lbu_after", 1'b1, LBU, 32'h55, 32'h0, 32'h0000007E, 32'h0000007E, 5'd12, 1'b1, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_alu(5'd5, 1'b1, 32'h00001234, 1'b1);
    test_alu(5'd0, 1'b1, 32'h00000077, 1'b0);
    run_mem("b2b_lw", 1'b1, LW, 32'h300, 32'h0, 32'h0BADCAFE, 32'h0BADCAFE, 5'd13, 1'b1, 32'h0, 0, 0, 1'b0);
    test_alu(5'd14, 1'b0, 32'h89ABCDEF, 1'b1);
  endtask

  task automatic test_random();
    logic        is_load;
    logic [1:0]  size;
    logic [2:0]  f3;
    logic [31:0] raw;
    for (int i = 0; i < 12; i++) begin
      is_load = 1'($urandom);
      size = 2'($urandom);
      f3 = is_load ? {1'($urandom), size} : {1'b0, size};
      raw = $urandom;
      run_mem("rand", is_load, f3, $urandom, $urandom, raw, model_load(f3, raw),
              5'($urandom), 1'($urandom), $urandom, int'($urandom_range(2, 0)), 2, 1'b1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu(5'd5, 1'b1, 32'h00001234, 1'b1);
    test_loads();
    test_store_hold();
    test_reset_mid_access();
    test_wrap_and_spurious();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_left got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
